// File: rtl/sram_stream_reader.sv
// Drains a contiguous SRAM bank region onto an AXI4-Stream master.
// Optional perf counters: define SRAM_STREAM_READER_PERF_EN.
module sram_stream_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            cfg_idx,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_out_en,
    output logic [2:0]            sram_out_idx,
    output logic [ADDR_WIDTH-1:0] sram_out_addr,
    input  logic                  sram_out_gnt,
    input  logic [DATA_WIDTH-1:0] sram_out_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef SRAM_STREAM_READER_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_nogrant_cycles,
    output logic [31:0]           perf_xfer_cycles
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [2:0]            r_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_sent;
    logic [RD_LAT-1:0]     r_vld_sr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;

    logic [CW-1:0]         w_inflight;
    logic [CW-1:0]         w_used;
    logic                  w_credit;
    logic                  w_req;
    logic                  w_take;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_accept;
    logic [LEN_WIDTH-1:0]  w_issued_nxt;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + CW'(r_vld_sr[i]);
        end
    end

    // Credits cover both buffered words and reads still in flight.
    assign w_used       = r_count + w_inflight;
    assign w_credit     = w_used < DEPTH_C;
    assign w_req        = (r_state == S_ISSUE) && w_credit;
    assign w_take       = w_req && sram_out_gnt;
    assign w_push       = r_vld_sr[RD_LAT-1];
    assign w_pop        = m_axis_tvalid && m_axis_tready;
    assign w_last       = r_sent == (r_len - LEN_WIDTH'(1));
    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_issued_nxt = r_issued + LEN_WIDTH'(1);

    assign busy          = r_busy;
    assign done          = r_done;
    assign sram_out_en   = w_req;
    assign sram_out_idx  = r_idx;
    assign sram_out_addr = r_addr;
    assign m_axis_tvalid = r_count != '0;
    assign m_axis_tdata  = r_mem[r_rptr];
    assign m_axis_tlast  = m_axis_tvalid && w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_idx    <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_issued <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx    <= cfg_idx;
                        r_addr   <= cfg_base_addr;
                        r_len    <= cfg_len;
                        r_issued <= '0;
                        if (cfg_len != '0) begin
                            r_state <= S_ISSUE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_take) begin
                        r_addr   <= r_addr + ADDR_WIDTH'(1);
                        r_issued <= w_issued_nxt;
                        if (w_issued_nxt == r_len) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_sr <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_sent   <= '0;
        end else begin
            r_vld_sr[0] <= w_take;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i] <= r_vld_sr[i-1];
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_accept) begin
                r_sent <= '0;
            end else if (w_pop) begin
                r_sent <= r_sent + LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= sram_out_data;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && w_push) begin
            assert (r_count != DEPTH_C);
        end
    end
`endif

`ifdef SRAM_STREAM_READER_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_nogrant;
    logic [31:0] r_perf_xfer;

    assign perf_stall_cycles   = r_perf_stall;
    assign perf_nogrant_cycles = r_perf_nogrant;
    assign perf_xfer_cycles    = r_perf_xfer;

    // All counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall   <= '0;
            r_perf_nogrant <= '0;
            r_perf_xfer    <= '0;
        end else if (w_accept) begin
            r_perf_stall   <= '0;
            r_perf_nogrant <= '0;
            r_perf_xfer    <= 32'd1;
        end else begin
            if (r_busy && m_axis_tvalid && !m_axis_tready
                && r_perf_stall != '1) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_req && !sram_out_gnt && r_perf_nogrant != '1) begin
                r_perf_nogrant <= r_perf_nogrant + 32'd1;
            end
            if (r_state != S_IDLE && r_perf_xfer != '1) begin
                r_perf_xfer <= r_perf_xfer + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Testbench for sram_stream_reader: vector table, SRAM model and scoreboard.
module tb_sram_stream_reader;

    localparam int DW = 64;
    localparam int AW = 8;
    localparam int LW = 16;
    localparam int BUDGET = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    cfg_idx = '0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [LW-1:0] cfg_len = '0;
    logic          busy;
    logic          done;
    logic          sram_out_en;
    logic [2:0]    sram_out_idx;
    logic [AW-1:0] sram_out_addr;
    logic          sram_out_gnt = 1'b1;
    logic [DW-1:0] sram_out_data = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
`ifdef SRAM_STREAM_READER_PERF_EN
    logic [31:0]   perf_stall_cycles;
    logic [31:0]   perf_nogrant_cycles;
    logic [31:0]   perf_xfer_cycles;
`endif

    sram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .RD_LAT     (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_idx       (cfg_idx),
        .cfg_base_addr (cfg_base_addr),
        .cfg_len       (cfg_len),
        .busy          (busy),
        .done          (done),
        .sram_out_en   (sram_out_en),
        .sram_out_idx  (sram_out_idx),
        .sram_out_addr (sram_out_addr),
        .sram_out_gnt  (sram_out_gnt),
        .sram_out_data (sram_out_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
`ifdef SRAM_STREAM_READER_PERF_EN
        ,
        .perf_stall_cycles   (perf_stall_cycles),
        .perf_nogrant_cycles (perf_nogrant_cycles),
        .perf_xfer_cycles    (perf_xfer_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    idx;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        bit            bp;
        bit            ign;
        bit            drop;
        logic [AW-1:0] drop_addr;
        int            exp_cyc;
        logic [DW-1:0] exp_first;
        logic [DW-1:0] exp_last;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic [DW-1:0] mem [8][256];
    beat_t         dq[$];
    logic [10:0]   aq[$];
    int            checks = 0;
    int            failures = 0;
    int            beats = 0;
    bit            en_seen = 0;
    bit            tv_seen = 0;
    bit            stall_prev = 0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    logic [DW-1:0] first_d = '0;
    logic [DW-1:0] last_d = '0;

    function automatic logic [DW-1:0] fillv(input logic [2:0] b,
                                            input logic [7:0] a);
        return {4'hD, 1'b0, b, 48'h0000_5EED_0000, a};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SRAM model, RD_LAT = 1
    always @(posedge clk) begin
        if (sram_out_en && sram_out_gnt) begin
            sram_out_data <= mem[sram_out_idx][sram_out_addr];
        end else begin
            sram_out_data <= {$urandom, $urandom};
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 0;
        end else begin
            if (sram_out_en) en_seen = 1;
            if (m_axis_tvalid) tv_seen = 1;
            if (stall_prev) begin
                chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
                chk("hold_data", m_axis_tdata, prev_d);
                chk("hold_last", 64'(m_axis_tlast), 64'(prev_l));
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
            if (sram_out_en && sram_out_gnt) begin
                if (aq.size() == 0) begin
                    fail_now("unexpected_request");
                end else begin
                    chk("req_idx_addr",
                        64'({sram_out_idx, sram_out_addr}),
                        64'(aq.pop_front()));
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (dq.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    beat_t e;
                    e = dq.pop_front();
                    chk("tdata", m_axis_tdata, e.d);
                    chk("tlast", 64'(m_axis_tlast), 64'(e.l));
                end
                if (beats == 0) first_d = m_axis_tdata;
                last_d = m_axis_tdata;
                beats++;
            end
        end
    end

    task automatic enqueue(input vec_t v);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.base + AW'(i);
            dq.push_back('{d: mem[v.idx][a],
                           l: (i == int'(v.len) - 1)});
            aq.push_back({v.idx, a});
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int n;
        int done_at;
        int dstate;
        en_seen = 0;
        tv_seen = 0;
        beats = 0;
        dstate = 0;
        done_at = 0;
        enqueue(v);
        tick();
        start = 1'b1;
        cfg_idx = v.idx;
        cfg_base_addr = v.base;
        cfg_len = v.len;
        tick();
        start = 1'b0;
        if (v.len != 0) chk("busy_after_start", 64'(busy), 64'd1);
        n = 1;
        while (done_at == 0 && n <= BUDGET) begin
            if (v.bp) m_axis_tready = (n % 4 == 0) || (n % 4 == 3);
            if (v.ign && n == 4) begin
                start = 1'b1;
                cfg_idx = 3'd7;
                cfg_base_addr = '0;
                cfg_len = 16'd3;
            end else if (v.ign && n == 5) begin
                start = 1'b0;
            end
            if (v.drop) begin
                if (dstate == 0 && sram_out_en
                    && sram_out_addr == v.drop_addr) begin
                    sram_out_gnt = 1'b0;
                    dstate = 1;
                end else if (dstate >= 1 && dstate <= 3) begin
                    chk("retry_en", 64'(sram_out_en), 64'd1);
                    chk("retry_addr", 64'(sram_out_addr),
                        64'(v.drop_addr));
                    if (dstate == 3) sram_out_gnt = 1'b1;
                    dstate++;
                end
            end
            if (done) begin
                done_at = n;
            end else begin
                tick();
                n++;
            end
        end
        m_axis_tready = 1'b1;
        sram_out_gnt = 1'b1;
        start = 1'b0;
        if (done_at == 0) begin
            fail_now("done_timeout");
        end else begin
            if (v.exp_cyc != 0) chk("done_latency", 64'(done_at),
                                    64'(v.exp_cyc));
            chk("busy_at_done", 64'(busy), 64'd0);
            chk("beats", 64'(beats), 64'(v.len));
            chk("data_left", 64'(dq.size()), 64'd0);
            chk("reqs_left", 64'(aq.size()), 64'd0);
            if (v.len != 0) begin
                chk("first_word", first_d, v.exp_first);
                chk("last_word", last_d, v.exp_last);
            end else begin
                chk("zero_len_en", 64'(en_seen), 64'd0);
                chk("zero_len_tvalid", 64'(tv_seen), 64'd0);
            end
            if (v.drop) chk("drop_seen", 64'(dstate), 64'd4);
            tick();
            chk("done_pulse_end", 64'(done), 64'd0);
        end
        dq.delete();
        aq.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_en"}, 64'(sram_out_en), 64'd0);
        chk({tag, "_addr"}, 64'(sram_out_addr), 64'd0);
        chk({tag, "_idx"}, 64'(sram_out_idx), 64'd0);
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t vr;
        int   n;

        for (int b = 0; b < 8; b++) begin
            for (int a = 0; a < 256; a++) begin
                mem[b][a] = fillv(3'(b), 8'(a));
            end
        end
        for (int i = 0; i < 8; i++) begin
            mem[2][8'h10 + i] = 64'hA0 + 64'(i);
        end

        vecs[0] = '{idx: 3'd2, base: 8'h10, len: 16'd8,
                    bp: 0, ign: 0, drop: 0, drop_addr: 8'h00,
                    exp_cyc: 11, exp_first: 64'hA0,
                    exp_last: 64'hA7};
        vecs[1] = '{idx: 3'd3, base: 8'h40, len: 16'd0,
                    bp: 0, ign: 0, drop: 0, drop_addr: 8'h00,
                    exp_cyc: 1, exp_first: 64'h0,
                    exp_last: 64'h0};
        vecs[2] = '{idx: 3'd1, base: 8'h20, len: 16'd16,
                    bp: 1, ign: 1, drop: 0, drop_addr: 8'h00,
                    exp_cyc: 0, exp_first: fillv(3'd1, 8'h20),
                    exp_last: fillv(3'd1, 8'h2F)};
        vecs[3] = '{idx: 3'd2, base: 8'h10, len: 16'd8,
                    bp: 0, ign: 0, drop: 1, drop_addr: 8'h13,
                    exp_cyc: 14, exp_first: 64'hA0,
                    exp_last: 64'hA7};
        vecs[4] = '{idx: 3'd5, base: 8'hFE, len: 16'd4,
                    bp: 0, ign: 0, drop: 0, drop_addr: 8'h00,
                    exp_cyc: 7, exp_first: fillv(3'd5, 8'hFE),
                    exp_last: fillv(3'd5, 8'h01)};
        vecs[5] = '{idx: 3'd6, base: 8'h33, len: 16'd1,
                    bp: 0, ign: 0, drop: 0, drop_addr: 8'h00,
                    exp_cyc: 4, exp_first: fillv(3'd6, 8'h33),
                    exp_last: fillv(3'd6, 8'h33)};

        repeat (3) tick();
        chk_idle_outputs("reset");
        rst = 1'b1;
        tick();

        foreach (vecs[k]) begin
            run_xfer(vecs[k]);
        end

        // Abort a transfer mid-stream with an asynchronous reset.
        vr = '{idx: 3'd4, base: 8'h50, len: 16'd10,
               bp: 0, ign: 0, drop: 0, drop_addr: 8'h00,
               exp_cyc: 0, exp_first: 64'h0, exp_last: 64'h0};
        beats = 0;
        enqueue(vr);
        tick();
        start = 1'b1;
        cfg_idx = vr.idx;
        cfg_base_addr = vr.base;
        cfg_len = vr.len;
        tick();
        start = 1'b0;
        n = 0;
        while (beats < 3 && n < BUDGET) begin
            tick();
            n++;
        end
        if (beats < 3) fail_now("abort_wait_timeout");
        rst = 1'b0;
        #1;
        chk_idle_outputs("abort");
        dq.delete();
        aq.delete();
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_done", 64'(done), 64'd0);
        end

        vr = '{idx: 3'd4, base: 8'h60, len: 16'd2,
               bp: 0, ign: 0, drop: 0, drop_addr: 8'h00,
               exp_cyc: 5, exp_first: fillv(3'd4, 8'h60),
               exp_last: fillv(3'd4, 8'h61)};
        run_xfer(vr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- DMA-style readback engine that drains a contiguous region of one bank of the multi-SRAM array onto an AXI4-Stream master.
- Drives the sram_controller's axi4 output request port (sram_out_en/idx/addr) and consumes sram_out_data.
- It is the read-side counterpart of the AXI write path that fills the banks.
- Sits between sram_controller and the output DMA/AXIS interconnect, and handles downstream backpressure through an internal credit-controlled FIFO.

Parameters:
- DATA_WIDTH, 64, SRAM word and m_axis_tdata width.
- ADDR_WIDTH, MAX_ADDR_WIDTH, SRAM word address width.
- LEN_WIDTH, 16, width of the beat-count field.
- RD_LAT, 1, cycles from a granted request to valid sram_out_data.
- FIFO_DEPTH, 4, output buffer entries; must be >= RD_LAT+2 and a power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_* when idle.
- cfg_idx  in  3  bank index to read.
- cfg_base_addr  in  ADDR_WIDTH  first word address.
- cfg_len  in  LEN_WIDTH  number of words (beats).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last beat handshakes.
- sram_out_en  out  1  read request to controller.
- sram_out_idx  out  3  bank index (held at latched cfg_idx while busy).
- sram_out_addr  out  ADDR_WIDTH  read word address.
- sram_out_gnt  in  1  high when the controller serviced sram_out_en this cycle; tied 1 when no higher-priority requester targets the bank.
- sram_out_data  in  DATA_WIDTH  read data, RD_LAT cycles after a granted request.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on final beat.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, done, sram_out_en, m_axis_tvalid and m_axis_tlast = 0; sram_out_addr, sram_out_idx = 0; FIFO emptied; all counters cleared. A reset mid-transfer aborts it with no done pulse.
- States:
  - IDLE: start with cfg_len!=0 -> ISSUE; busy=1; latch idx, base and len. Start with cfg_len==0 -> DONE (done pulse, no beats, no SRAM access).
  - ISSUE: sram_out_en=1 when credits>0, where credits = FIFO_DEPTH - fifo_count - inflight. A request is taken only when sram_out_en && sram_out_gnt. On each taken request: issue counter +1 and address +1 (wraps modulo 2^ADDR_WIDTH). When issued==len -> DRAIN, and sram_out_en deasserts the same cycle as the last taken request's successor.
  - DRAIN: no requests; stay until every beat has handshaken -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- Read return: an RD_LAT-deep valid shift register tracks taken requests; each returning valid pushes sram_out_data into the FIFO. By construction the credit rule means a push never occurs when the FIFO is full (assert in simulation).
- Stream output: m_axis_tvalid = FIFO non-empty; tdata = FIFO head.
  - Pop on tvalid && tready.
  - tlast=1 when the head entry is beat len-1 (sent counter == len-1).
  - tdata and tlast hold stable while tvalid && !tready.
- Simultaneous push and pop are allowed; fifo_count is unchanged.
- An ungranted request (sram_out_gnt=0) is retried at the same address the next cycle with no data push.
- Start while busy is ignored.
- Throughput: one beat per cycle with tready=1, gnt=1 and FIFO_DEPTH>=RD_LAT+2.
- First-beat latency: tvalid rises RD_LAT+1 cycles after the first granted request (one cycle for the FIFO write).

Optional Feature:
- Macro: SRAM_STREAM_READER_PERF_EN.
- With the macro defined, three extra outputs are added, all 32-bit:
  - perf_stall_cycles: cycles with busy && (tvalid && !tready).
  - perf_nogrant_cycles: cycles with sram_out_en && !sram_out_gnt.
  - perf_xfer_cycles: cycles from start accept to done, inclusive.
- All three counters clear on reset and on each accepted start, and saturate at all-ones.
- Without the macro these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic transfer: preload bank 2 addr 0x10..0x17 with 0xA0..0xA7; start idx=2 base=0x10 len=8, tready=1, gnt=1 -> 8 beats 0xA0..0xA7 on consecutive cycles, tlast only on 0xA7, done one cycle after.
- Zero length: start len=0 -> done on the next cycle, sram_out_en never asserted, no tvalid.
- Backpressure: len=16, tready toggles 1,0,0,1 repeating -> all 16 words in order, no loss or duplication, tdata stable while stalled, FIFO never overflows.
- Grant loss: gnt=0 for 3 cycles mid-transfer at addr 0x13 -> addr 0x13 is re-presented until granted, and the output sequence is unchanged.
- Address wrap: ADDR_WIDTH=8, base=0xFE, len=4 -> reads 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-operation: assert rst after 3 beats of a len=10 transfer -> all outputs 0 immediately, no done. A fresh start len=2 then completes normally.
